// File: rtl/acc_interconnect.sv
// Q/P accelerator interconnect: address-routed requests with per-responder round-robin,
// ID-extended responses routed back per requester. Define ACC_INTERCONNECT_CUT_EN to add spill cuts.
module acc_rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          ready_i,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   j;

  // Scan downwards so the slot at ptr_q (highest priority) is written last.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    j         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr_q} + (IW+1)'(k);
      if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
      if (req_i[j[IW-1:0]]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = j[IW-1:0];
      end
    end
  end

  // A stall parks the pointer on the grantee, which holds the grant until the handshake.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_o) begin
      if (!ready_i)                       ptr_d = gnt_idx_o;
      else if (gnt_idx_o == IW'(N - 1))   ptr_d = '0;
      else                                ptr_d = gnt_idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

`ifdef ACC_INTERCONNECT_CUT_EN
module acc_spill #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wp_q, wp_d, rp_q, rp_d, rdy_q, rdy_d, push, pop;
  logic [1:0]        cnt_q, cnt_d;

  assign push        = in_valid_i && rdy_q;
  assign pop         = (cnt_q != 2'd0) && out_ready_i;
  assign in_ready_o  = rdy_q;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rp_q];

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = in_data_i;
    wp_d  = wp_q ^ push;
    rp_d  = rp_q ^ pop;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0; wp_q <= 1'b0; rp_q <= 1'b0; cnt_q <= '0; rdy_q <= 1'b0;
    end else begin
      mem_q <= mem_d; wp_q <= wp_d; rp_q <= rp_d; cnt_q <= cnt_d; rdy_q <= rdy_d;
    end
  end
endmodule
`endif

module acc_interconnect #(
  parameter int NumReq    = 2,
  parameter int NumRsp    = 2,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5,
  parameter int IdWidth   = 5,
  parameter int IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NumReq-1:0][AddrWidth-1:0]          req_q_addr_i,
  input  logic [NumReq-1:0][31:0]                   req_q_data_op_i,
  input  logic [NumReq-1:0][DataWidth-1:0]          req_q_data_arga_i,
  input  logic [NumReq-1:0][DataWidth-1:0]          req_q_data_argb_i,
  input  logic [NumReq-1:0][DataWidth-1:0]          req_q_data_argc_i,
  input  logic [NumReq-1:0][IdWidth-1:0]            req_q_id_i,
  input  logic [NumReq-1:0]                         req_q_valid_i,
  output logic [NumReq-1:0]                         req_q_ready_o,
  output logic [NumReq-1:0][DataWidth-1:0]          req_p_data_o,
  output logic [NumReq-1:0][IdWidth-1:0]            req_p_id_o,
  output logic [NumReq-1:0]                         req_p_error_o,
  output logic [NumReq-1:0]                         req_p_valid_o,
  input  logic [NumReq-1:0]                         req_p_ready_i,
  output logic [NumRsp-1:0][AddrWidth-1:0]          rsp_q_addr_o,
  output logic [NumRsp-1:0][31:0]                   rsp_q_data_op_o,
  output logic [NumRsp-1:0][DataWidth-1:0]          rsp_q_data_arga_o,
  output logic [NumRsp-1:0][DataWidth-1:0]          rsp_q_data_argb_o,
  output logic [NumRsp-1:0][DataWidth-1:0]          rsp_q_data_argc_o,
  output logic [NumRsp-1:0][IdWidth+IdxWidth-1:0]   rsp_q_id_o,
  output logic [NumRsp-1:0]                         rsp_q_valid_o,
  input  logic [NumRsp-1:0]                         rsp_q_ready_i,
  input  logic [NumRsp-1:0][DataWidth-1:0]          rsp_p_data_i,
  input  logic [NumRsp-1:0][IdWidth+IdxWidth-1:0]   rsp_p_id_i,
  input  logic [NumRsp-1:0]                         rsp_p_error_i,
  input  logic [NumRsp-1:0]                         rsp_p_valid_i,
  output logic [NumRsp-1:0]                         rsp_p_ready_o
);
  localparam int RIdW = IdWidth + IdxWidth;
  localparam int SrcW = $clog2(NumRsp + 1);
  localparam int QW   = AddrWidth + 32 + 3 * DataWidth + RIdW;
  localparam int PW   = DataWidth + IdWidth + 1;

  // Q side: destination NumRsp is the local error slot.
  logic [NumRsp:0][NumReq-1:0]   q_sel;
  logic [NumRsp:0][IdxWidth-1:0] q_gnt;
  logic [NumRsp:0]               q_gv, q_rdy;

  always_comb begin
    q_sel = '0;
    for (int i = 0; i < NumReq; i++)
      for (int d = 0; d <= NumRsp; d++)
        if (req_q_valid_i[i]) begin
          if (int'(req_q_addr_i[i]) < NumRsp) q_sel[d][i] = (int'(req_q_addr_i[i]) == d);
          else                                q_sel[d][i] = (d == NumRsp);
        end
  end

  for (genvar d = 0; d <= NumRsp; d++) begin : g_qarb
    acc_rr_arb #(.N(NumReq), .IW(IdxWidth)) u_arb (
      .clk_i, .rst_ni, .req_i(q_sel[d]), .ready_i(q_rdy[d]),
      .gnt_idx_o(q_gnt[d]), .gnt_vld_o(q_gv[d]));
  end

  always_comb begin
    req_q_ready_o = '0;
    for (int d = 0; d <= NumRsp; d++)
      if (q_gv[d] && q_rdy[d]) req_q_ready_o[q_gnt[d]] = 1'b1;
  end

  for (genvar r = 0; r < NumRsp; r++) begin : g_qout
    logic [QW-1:0] q_pay, q_out;
    assign q_pay = {req_q_addr_i[q_gnt[r]], req_q_data_op_i[q_gnt[r]], req_q_data_arga_i[q_gnt[r]],
                    req_q_data_argb_i[q_gnt[r]], req_q_data_argc_i[q_gnt[r]], q_gnt[r],
                    req_q_id_i[q_gnt[r]]};
`ifdef ACC_INTERCONNECT_CUT_EN
    acc_spill #(.W(QW)) u_spill (
      .clk_i, .rst_ni, .in_valid_i(q_gv[r]), .in_ready_o(q_rdy[r]), .in_data_i(q_pay),
      .out_valid_o(rsp_q_valid_o[r]), .out_ready_i(rsp_q_ready_i[r]), .out_data_o(q_out));
`else
    assign q_out            = q_pay;
    assign rsp_q_valid_o[r] = q_gv[r];
    assign q_rdy[r]         = rsp_q_ready_i[r];
`endif
    assign {rsp_q_addr_o[r], rsp_q_data_op_o[r], rsp_q_data_arga_o[r], rsp_q_data_argb_o[r],
            rsp_q_data_argc_o[r], rsp_q_id_o[r]} = q_out;
  end

  // One-entry error slot, always registered.
  typedef enum logic {ERR_IDLE, ERR_BUSY} err_state_e;
  err_state_e          err_q, err_d;
  logic [IdxWidth-1:0] err_idx_q, err_idx_d;
  logic [IdWidth-1:0]  err_id_q, err_id_d;
  logic                err_p_rdy;

  assign q_rdy[NumRsp] = (err_q == ERR_IDLE);

  always_comb begin
    err_d     = err_q;
    err_idx_d = err_idx_q;
    err_id_d  = err_id_q;
    case (err_q)
      ERR_IDLE: if (q_gv[NumRsp]) begin
        err_d     = ERR_BUSY;
        err_idx_d = q_gnt[NumRsp];
        err_id_d  = req_q_id_i[q_gnt[NumRsp]];
      end
      ERR_BUSY: if (err_p_rdy) err_d = ERR_IDLE;
      default:  err_d = ERR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= ERR_IDLE; err_idx_q <= '0; err_id_q <= '0;
    end else begin
      err_q <= err_d; err_idx_q <= err_idx_d; err_id_q <= err_id_d;
    end
  end

  // P side: source NumRsp is the error slot.
  logic [NumRsp:0]                 p_src_vld, p_src_rdy;
  logic [NumRsp:0][IdxWidth-1:0]   p_src_dst;
  logic [NumRsp:0][PW-1:0]         p_src_pay;
  logic [NumReq-1:0][NumRsp:0]     p_sel;
  logic [NumReq-1:0][SrcW-1:0]     p_gnt;
  logic [NumReq-1:0]               p_gv, p_rdy;

  always_comb begin
    p_src_vld = '0;
    p_src_dst = '0;
    p_src_pay = '0;
    for (int r = 0; r < NumRsp; r++) begin
      p_src_vld[r] = rsp_p_valid_i[r];
      p_src_dst[r] = rsp_p_id_i[r][IdWidth +: IdxWidth];
      p_src_pay[r] = {rsp_p_data_i[r], rsp_p_id_i[r][IdWidth-1:0], rsp_p_error_i[r]};
    end
    p_src_vld[NumRsp] = (err_q == ERR_BUSY);
    p_src_dst[NumRsp] = err_idx_q;
    p_src_pay[NumRsp] = {{DataWidth{1'b0}}, err_id_q, 1'b1};
  end

  always_comb begin
    p_sel     = '0;
    p_src_rdy = '0;
    for (int j = 0; j < NumReq; j++) begin
      for (int s = 0; s <= NumRsp; s++)
        p_sel[j][s] = p_src_vld[s] && (int'(p_src_dst[s]) == j);
      if (p_gv[j] && p_rdy[j]) p_src_rdy[p_gnt[j]] = 1'b1;
    end
  end

  assign rsp_p_ready_o = p_src_rdy[NumRsp-1:0];
  assign err_p_rdy     = p_src_rdy[NumRsp];

  for (genvar j = 0; j < NumReq; j++) begin : g_pout
    logic [PW-1:0] p_out;
    acc_rr_arb #(.N(NumRsp + 1), .IW(SrcW)) u_arb (
      .clk_i, .rst_ni, .req_i(p_sel[j]), .ready_i(p_rdy[j]),
      .gnt_idx_o(p_gnt[j]), .gnt_vld_o(p_gv[j]));
`ifdef ACC_INTERCONNECT_CUT_EN
    acc_spill #(.W(PW)) u_spill (
      .clk_i, .rst_ni, .in_valid_i(p_gv[j]), .in_ready_o(p_rdy[j]), .in_data_i(p_src_pay[p_gnt[j]]),
      .out_valid_o(req_p_valid_o[j]), .out_ready_i(req_p_ready_i[j]), .out_data_o(p_out));
`else
    assign p_out            = p_src_pay[p_gnt[j]];
    assign req_p_valid_o[j] = p_gv[j];
    assign p_rdy[j]         = req_p_ready_i[j];
`endif
    assign {req_p_data_o[j], req_p_id_o[j], req_p_error_o[j]} = p_out;
  end
endmodule

// File: tb/tb_acc_interconnect.sv
// Scoreboard bench for acc_interconnect (2 requesters, 2 responders, combinational build).
module tb_acc_interconnect;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0][4:0]  q_addr, q_id;
  logic [1:0][31:0] q_op, q_a, q_b, q_c;
  logic [1:0]       q_valid, q_ready;
  logic [1:0][31:0] p_data;
  logic [1:0][4:0]  p_id;
  logic [1:0]       p_err, p_valid, p_ready;
  logic [1:0][4:0]  sq_addr;
  logic [1:0][31:0] sq_op, sq_a, sq_b, sq_c;
  logic [1:0][5:0]  sq_id;
  logic [1:0]       sq_valid, sq_ready;
  logic [1:0][31:0] sp_data;
  logic [1:0][5:0]  sp_id;
  logic [1:0]       sp_err, sp_valid, sp_ready;

  int tests = 0;
  int fails = 0;
  logic [37:0] qexp0[$], qexp1[$], pexp0[$], pexp1[$];
  logic [37:0] got, want;

  acc_interconnect dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_q_addr_i(q_addr), .req_q_data_op_i(q_op), .req_q_data_arga_i(q_a),
    .req_q_data_argb_i(q_b), .req_q_data_argc_i(q_c), .req_q_id_i(q_id),
    .req_q_valid_i(q_valid), .req_q_ready_o(q_ready),
    .req_p_data_o(p_data), .req_p_id_o(p_id), .req_p_error_o(p_err),
    .req_p_valid_o(p_valid), .req_p_ready_i(p_ready),
    .rsp_q_addr_o(sq_addr), .rsp_q_data_op_o(sq_op), .rsp_q_data_arga_o(sq_a),
    .rsp_q_data_argb_o(sq_b), .rsp_q_data_argc_o(sq_c), .rsp_q_id_o(sq_id),
    .rsp_q_valid_o(sq_valid), .rsp_q_ready_i(sq_ready),
    .rsp_p_data_i(sp_data), .rsp_p_id_i(sp_id), .rsp_p_error_i(sp_err),
    .rsp_p_valid_i(sp_valid), .rsp_p_ready_o(sp_ready)
  );

  // Scoreboard: every handshake on an output channel pops and compares the next expected entry.
  always @(negedge clk) begin
    #3;
    if (sq_valid[0] && sq_ready[0]) begin
      tests++; got = {sq_id[0], sq_a[0]};
      if (qexp0.size() == 0) begin fails++; $display("FAIL rsp0_q_unexpected got=%h", got); end
      else begin want = qexp0.pop_front();
        if (got !== want) begin fails++; $display("FAIL rsp0_q got=%h exp=%h", got, want); end end
    end
    if (sq_valid[1] && sq_ready[1]) begin
      tests++; got = {sq_id[1], sq_a[1]};
      if (qexp1.size() == 0) begin fails++; $display("FAIL rsp1_q_unexpected got=%h", got); end
      else begin want = qexp1.pop_front();
        if (got !== want) begin fails++; $display("FAIL rsp1_q got=%h exp=%h", got, want); end end
    end
    if (p_valid[0] && p_ready[0]) begin
      tests++; got = {p_err[0], p_id[0], p_data[0]};
      if (pexp0.size() == 0) begin fails++; $display("FAIL req0_p_unexpected got=%h", got); end
      else begin want = pexp0.pop_front();
        if (got !== want) begin fails++; $display("FAIL req0_p got=%h exp=%h", got, want); end end
    end
    if (p_valid[1] && p_ready[1]) begin
      tests++; got = {p_err[1], p_id[1], p_data[1]};
      if (pexp1.size() == 0) begin fails++; $display("FAIL req1_p_unexpected got=%h", got); end
      else begin want = pexp1.pop_front();
        if (got !== want) begin fails++; $display("FAIL req1_p got=%h exp=%h", got, want); end end
    end
  end

  task automatic idle_inputs();
    q_addr = '0; q_id = '0; q_op = '0; q_a = '0; q_b = '0; q_c = '0; q_valid = '0;
    p_ready = '1; sq_ready = '1;
    sp_data = '0; sp_id = '0; sp_err = '0; sp_valid = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    tests++; if (sq_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_q_valid got=%b exp=00", sq_valid); end
    tests++; if (p_valid !== 2'b00) begin fails++; $display("FAIL reset_req_p_valid got=%b exp=00", p_valid); end
    tests++; if (q_ready !== 2'b00) begin fails++; $display("FAIL reset_req_q_ready got=%b exp=00", q_ready); end
    tests++; if (sp_ready !== 2'b00) begin fails++; $display("FAIL reset_rsp_p_ready got=%b exp=00", sp_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    tests++; if (p_valid !== 2'b00) begin fails++; $display("FAIL post_reset_req_p_valid got=%b exp=00", p_valid); end
  endtask

  task automatic test_route();
    @(negedge clk);
    q_addr[0] = 5'd1; q_id[0] = 5'd3; q_a[0] = 32'h1111; q_valid[0] = 1'b1;
    qexp1.push_back({6'h03, 32'h1111});
    #1;
    tests++; if (sq_valid !== 2'b10) begin fails++; $display("FAIL route_rsp_q_valid got=%b exp=10", sq_valid); end
    tests++; if (sq_id[1] !== 6'h03) begin fails++; $display("FAIL route_rsp_q_id got=%h exp=03", sq_id[1]); end
    tests++; if (q_ready !== 2'b01) begin fails++; $display("FAIL route_req_q_ready got=%b exp=01", q_ready); end
    @(negedge clk);
    q_valid = '0;
    sp_valid = 2'b11; sp_err = '0;
    sp_id[1] = {1'b0, 5'd3}; sp_data[1] = 32'hCAFE;
    sp_id[0] = {1'b1, 5'd7}; sp_data[0] = 32'hBEEF;
    pexp0.push_back({1'b0, 5'd3, 32'hCAFE});
    pexp1.push_back({1'b0, 5'd7, 32'hBEEF});
    #1;
    tests++; if (sp_ready !== 2'b11) begin fails++; $display("FAIL route_rsp_p_ready got=%b exp=11", sp_ready); end
    tests++; if (p_valid !== 2'b11) begin fails++; $display("FAIL route_req_p_valid got=%b exp=11", p_valid); end
    @(negedge clk);
    sp_valid = '0;
  endtask

  task automatic test_rr_alternate();
    logic [1:0] exp_rdy;
    @(negedge clk);
    q_addr = '0; q_id[0] = 5'd1; q_id[1] = 5'd2; q_a[0] = 32'hA0; q_a[1] = 32'hA1; q_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) qexp0.push_back({6'h01, 32'hA0});
      else            qexp0.push_back({6'h22, 32'hA1});
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      tests++; if (q_ready !== exp_rdy) begin fails++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", k, q_ready, exp_rdy); end
      @(negedge clk);
    end
    q_valid = '0;
  endtask

  task automatic test_lock();
    @(negedge clk);
    sq_ready[0] = 1'b0; q_valid = 2'b11;
    qexp0.push_back({6'h01, 32'hA0});
    qexp0.push_back({6'h22, 32'hA1});
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++; if ({sq_valid[0], sq_id[0], sq_a[0]} !== {1'b1, 6'h01, 32'hA0}) begin
        fails++; $display("FAIL lock_payload cycle=%0d got=%b/%h/%h exp=1/01/a0", k, sq_valid[0], sq_id[0], sq_a[0]); end
      tests++; if (q_ready !== 2'b00) begin fails++; $display("FAIL lock_ready cycle=%0d got=%b exp=00", k, q_ready); end
      @(negedge clk);
    end
    sq_ready[0] = 1'b1;
    #1;
    tests++; if (q_ready !== 2'b01) begin fails++; $display("FAIL lock_release got=%b exp=01", q_ready); end
    @(negedge clk); #1;
    tests++; if (q_ready !== 2'b10) begin fails++; $display("FAIL lock_next_grant got=%b exp=10", q_ready); end
    @(negedge clk);
    q_valid = '0;
  endtask

  task automatic test_error();
    @(negedge clk);
    p_ready[0] = 1'b0; q_addr[0] = 5'd7; q_id[0] = 5'd9; q_valid[0] = 1'b1;
    pexp0.push_back({1'b1, 5'd9, 32'h0});
    pexp0.push_back({1'b1, 5'd10, 32'h0});
    #1;
    tests++; if (sq_valid !== 2'b00) begin fails++; $display("FAIL err_no_rsp_valid got=%b exp=00", sq_valid); end
    tests++; if (q_ready !== 2'b01) begin fails++; $display("FAIL err_accept got=%b exp=01", q_ready); end
    @(negedge clk);
    q_addr[0] = 5'd6; q_id[0] = 5'd10;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if ({p_valid[0], p_err[0], p_id[0], p_data[0]} !== {1'b1, 1'b1, 5'd9, 32'h0}) begin
        fails++; $display("FAIL err_resp cycle=%0d got=%b/%b/%h/%h exp=1/1/09/0", k, p_valid[0], p_err[0], p_id[0], p_data[0]); end
      tests++; if (q_ready[0] !== 1'b0) begin fails++; $display("FAIL err_second_stall cycle=%0d got=%b exp=0", k, q_ready[0]); end
      @(negedge clk);
    end
    p_ready[0] = 1'b1;
    #1;
    tests++; if (q_ready[0] !== 1'b0) begin fails++; $display("FAIL err_drain_first got=%b exp=0", q_ready[0]); end
    @(negedge clk); #1;
    tests++; if ({p_valid[0], q_ready[0]} !== 2'b01) begin fails++; $display("FAIL err_idle_again got=%b exp=01", {p_valid[0], q_ready[0]}); end
    @(negedge clk);
    q_valid = '0;
    #1;
    tests++; if ({p_valid[0], p_id[0]} !== {1'b1, 5'd10}) begin fails++; $display("FAIL err_second_resp got=%b/%h exp=1/0a", p_valid[0], p_id[0]); end
    @(negedge clk); #1;
    tests++; if (p_valid !== 2'b00) begin fails++; $display("FAIL err_drained got=%b exp=00", p_valid); end
  endtask

  task automatic test_p_rr();
    @(negedge clk);
    sp_valid = 2'b11;
    sp_id[0] = {1'b0, 5'd4}; sp_data[0] = 32'h1000;
    sp_id[1] = {1'b0, 5'd5}; sp_data[1] = 32'h2000;
    pexp0.push_back({1'b0, 5'd4, 32'h1000});
    pexp0.push_back({1'b0, 5'd5, 32'h2000});
    #1;
    tests++; if (sp_ready !== 2'b01) begin fails++; $display("FAIL prr_first got=%b exp=01", sp_ready); end
    @(negedge clk);
    sp_valid[0] = 1'b0;
    #1;
    tests++; if (sp_ready !== 2'b10) begin fails++; $display("FAIL prr_second got=%b exp=10", sp_ready); end
    @(negedge clk);
    sp_valid = '0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    p_ready[0] = 1'b0; q_addr[0] = 5'd7; q_id[0] = 5'd4; q_valid[0] = 1'b1;
    @(negedge clk);
    q_valid = '0;
    #1;
    tests++; if (p_valid[0] !== 1'b1) begin fails++; $display("FAIL areset_pre got=%b exp=1", p_valid[0]); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (p_valid !== 2'b00) begin fails++; $display("FAIL areset_valid got=%b exp=00", p_valid); end
    @(negedge clk);
    rst_n = 1'b1; p_ready = '1;
    @(negedge clk); #1;
    tests++; if (p_valid !== 2'b00) begin fails++; $display("FAIL areset_slot_idle got=%b exp=00", p_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_route();
    test_rr_alternate();
    test_lock();
    test_error();
    test_p_rr();
    test_async_reset();
    @(negedge clk); #1;
    tests++;
    if (qexp0.size() + qexp1.size() + pexp0.size() + pexp1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover got=%0d/%0d/%0d/%0d exp=0/0/0/0",
               qexp0.size(), qexp1.size(), pexp0.size(), pexp1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
